// File: rtl/mips_cpu_multdiv.sv
`default_nettype none
// ============================================================================
//  Module   : mips_cpu_multdiv
//  Purpose  : Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning HI/LO.
//  Revision : 1.0 - initial release
// ============================================================================
module mips_cpu_multdiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] c_OP_MULT  = 3'd0;
    localparam logic [2:0] c_OP_MULTU = 3'd1;
    localparam logic [2:0] c_OP_DIV   = 3'd2;
    localparam logic [2:0] c_OP_DIVU  = 3'd3;
    localparam logic [2:0] c_OP_MTHI  = 3'd4;
    localparam logic [2:0] c_OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic             r_signed;
    logic             r_div0;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic             r_sign_q;
    logic             r_sign_r;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_is_mul;
    logic             w_is_div;
    logic             w_b_zero;
    logic             w_sdiv;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;

    logic [2*WIDTH-1:0] w_ext_x;
    logic [2*WIDTH-1:0] w_ext_y;
    logic [2*WIDTH-1:0] w_prod;

    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;

    assign w_accept = start && (r_state == S_IDLE);
    assign w_is_mul = (op == c_OP_MULT) || (op == c_OP_MULTU);
    assign w_is_div = (op == c_OP_DIV)  || (op == c_OP_DIVU);
    assign w_b_zero = (b == '0);
    assign w_sdiv   = (op == c_OP_DIV);
    assign w_abs_a  = (w_sdiv && a[WIDTH-1]) ? -a : a;
    assign w_abs_b  = (w_sdiv && b[WIDTH-1]) ? -b : b;

    // Sign-extending to double width lets one unsigned multiply serve both MULT and MULTU.
    assign w_ext_x  = {{WIDTH{r_signed & r_x[WIDTH-1]}}, r_x};
    assign w_ext_y  = {{WIDTH{r_signed & r_y[WIDTH-1]}}, r_y};
    assign w_prod   = w_ext_x * w_ext_y;

    // Restoring step: the shifted remainder needs one extra bit before the compare.
    assign w_shift  = {r_rem, r_quo[WIDTH-1]};
    assign w_ge     = (w_shift >= {1'b0, r_dvs});
    assign w_diff   = w_shift[WIDTH-1:0] - r_dvs;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_is_mul || (w_is_div && w_b_zero)) begin
                        w_next = S_MUL;
                    end else if (w_is_div) begin
                        w_next = S_DIV;
                    end
                end
            end
            S_MUL:   w_next = S_IDLE;
            S_DIV:   if (r_cnt == CW'(WIDTH - 1)) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_signed <= 1'b0;
            r_div0   <= 1'b0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        case (op)
                            c_OP_MTHI: r_hi <= a;
                            c_OP_MTLO: r_lo <= a;
                            c_OP_MULT, c_OP_MULTU: begin
                                r_x      <= a;
                                r_y      <= b;
                                r_signed <= (op == c_OP_MULT);
                                r_div0   <= 1'b0;
                            end
                            c_OP_DIV, c_OP_DIVU: begin
                                if (w_b_zero) begin
                                    r_x    <= a;
                                    r_div0 <= 1'b1;
                                end else begin
                                    r_quo    <= w_abs_a;
                                    r_dvs    <= w_abs_b;
                                    r_rem    <= '0;
                                    r_cnt    <= '0;
                                    r_sign_q <= w_sdiv & (a[WIDTH-1] ^ b[WIDTH-1]);
                                    r_sign_r <= w_sdiv & a[WIDTH-1];
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (r_div0) begin
                        r_hi <= r_x;
                        r_lo <= '1;
                    end else begin
                        {r_hi, r_lo} <= w_prod;
                    end
                    r_done <= 1'b1;
                end
                S_DIV: begin
                    r_rem <= w_ge ? w_diff : w_shift[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    r_lo   <= r_sign_q ? -r_quo : r_quo;
                    r_hi   <= r_sign_r ? -r_rem : r_rem;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_multdiv.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mips_cpu_multdiv
//  Purpose  : Scoreboard bench for the HI/LO multiply/divide unit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mips_cpu_multdiv;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] sb_q[$];

    always #5 clk = ~clk;

    mips_cpu_multdiv #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference {hi,lo}; SV '/' and '%' on signed values truncate toward zero.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] p;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        p  = '0;
        case (o)
            3'd0: p = sx * sy;
            3'd1: p = {32'd0, x} * {32'd0, y};
            3'd2, 3'd3: begin
                if (y == 32'd0) begin
                    p = {x, 32'hFFFFFFFF};
                end else if (o == 3'd2) begin
                    q = sx / sy;
                    r = sx % sy;
                    p = {r[31:0], q[31:0]};
                end else begin
                    p = {x % y, x / y};
                end
            end
            default: p = '0;
        endcase
        return p;
    endfunction

    initial begin : mon
        logic [63:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("hilo_result", {hi, lo}, e);
                end
            end
        end
    end

    // Issue one op, optionally poke an ignored MULT at busy cycle ign_at, and end in the done cycle.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [63:0] exp, input int lat, input int ign_at);
        logic [63:0] hl0;
        logic        stable;
        int          cnt;
        sb_q.push_back(exp);
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        hl0 = {hi, lo};
        stable = 1'b1;
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            cnt++;
            if ({hi, lo} !== hl0) stable = 1'b0;
            if (cnt == ign_at) begin
                start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd5;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        check_eq("busy_cycles", 64'(cnt), 64'(lat));
        check_eq("hilo_stable_while_busy", {63'd0, stable}, 64'd1);
        check_eq("done_pulse", {63'd0, done}, 64'd1);
    endtask

    initial begin : main
        logic [63:0] hl;
        logic [31:0] x, y;
        logic [2:0]  o;
        int          cnt;
        reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
        repeat (3) tick();
        check_eq("reset_busy_done", {62'd0, busy, done}, 64'd0);
        check_eq("reset_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;
        tick();

        op = 3'd4; a = 32'h12345678; start = 1'b1;
        tick();
        check_eq("mthi_hi", {32'd0, hi}, {32'd0, 32'h12345678});
        check_eq("mthi_busy", {62'd0, busy, done}, 64'd0);
        op = 3'd5; a = 32'h9ABCDEF0;
        tick();
        check_eq("mtlo_hilo", {hi, lo}, {32'h12345678, 32'h9ABCDEF0});
        check_eq("mtlo_busy", {62'd0, busy, done}, 64'd0);
        start = 1'b0;
        tick();
        check_eq("mt_no_done", {62'd0, busy, done}, 64'd0);

        run_op(3'd0, 32'hFFFFFFFE, 32'd3, {32'hFFFFFFFF, 32'hFFFFFFFA}, 1, 0);
        run_op(3'd1, 32'hFFFFFFFE, 32'd3, {32'h00000002, 32'hFFFFFFFA}, 1, 0);
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 0);
        run_op(3'd3, 32'hFFFFFFF9, 32'd2, {32'h00000001, 32'h7FFFFFFC}, 33, 0);
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}, 33, 0);
        run_op(3'd3, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF}, 1, 0);
        run_op(3'd2, 32'd1000, 32'hFFFFFFF9, {32'd6, 32'hFFFFFF72}, 33, 10);
        run_op(3'd0, 32'd12345, 32'hFFFF0000, model(3'd0, 32'd12345, 32'hFFFF0000), 1, 0);

        hl = {hi, lo};
        op = 3'd6; a = 32'hDEADBEEF; start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("unused_op_busy", {62'd0, busy, done}, 64'd0);
        check_eq("unused_op_hilo", {hi, lo}, hl);
        tick();
        check_eq("unused_op_no_done", {63'd0, done}, 64'd0);

        op = 3'd2; a = 32'd100; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        cnt = 1;
        while (cnt < 15) begin
            tick();
            cnt++;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("abort_busy_done", {62'd0, busy, done}, 64'd0);
        check_eq("abort_hilo", {hi, lo}, 64'd0);
        run_op(3'd3, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 0);

        for (int i = 0; i < 6; i++) begin
            o = 3'($urandom_range(0, 3));
            x = $urandom;
            y = (i == 3) ? 32'd0 : $urandom;
            if (i == 4) y = 32'd13;
            run_op(o, x, y, model(o, x, y), (o >= 3'd2 && y != 32'd0) ? 33 : 1, 0);
        end

        tick();
        tick();
        check_eq("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_cpu_multdiv.md
Name: mips_cpu_multdiv

Overview:
- Multi-cycle multiply/divide unit in the execute stage, alongside the ALU. It takes the same a/b operands from the register-read stage.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. Results go to architectural HI/LO registers, which MFHI/MFLO read back through the ALU pass-through path.
- Asserts busy so the controller stalls any HI/LO access or new mult/div request until the result is written.

Parameters:
- WIDTH, 32, operand and HI/LO width. The MIPS core always uses 32.

Ports:
- clk    input   1      system clock; all state updates on posedge
- reset  input   1      synchronous, active-high reset
- start  input   1      request strobe; sampled at posedge only while busy=0
- op     input   3      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are ignored
- a      input   WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source)
- b      input   WIDTH  rt operand (divisor / multiplier)
- busy   output  1      operation in progress; start is ignored while high
- done   output  1      one-cycle pulse; HI/LO hold the new result in this cycle
- hi     output  WIDTH  HI register
- lo     output  WIDTH  LO register

Behaviour:
- Reset (posedge with reset=1): state IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Reset has priority over start and aborts any operation in flight; partial results are discarded.
- States: IDLE, MUL, DIV, FIX.
- done defaults to 0 every cycle and is set for exactly one cycle after a write edge.
- Acceptance: start=1 and busy=0 at edge E0. Operands and op are latched at E0; a/b may change afterwards. Start is accepted in the same cycle done=1, so back-to-back operations are allowed.
- MTHI/MTLO: hi<=a (or lo<=a) at E0. State stays IDLE, busy stays 0, no done pulse.
- MULT/MULTU: E0 latches operands, IDLE->MUL, busy=1.
  - E1 writes {hi,lo} = the full 64-bit product: signed (sign-extended operands) for MULT, zero-extended for MULTU.
  - After E1: state IDLE, busy=0, done=1.
  - Total: busy high 1 cycle.
- DIV/DIVU, b!=0:
  - E0 latches the magnitudes. For DIV these are |a| and |b|, plus sign_q = a[31]^b[31] and sign_r = a[31]. For DIVU the operands are taken as-is with both signs 0.
  - E0 clears the partial remainder and counter; IDLE->DIV, busy=1.
  - E1..E32: one restoring step per edge.
    - Shift {rem,quo} left 1.
    - If rem >= divisor: rem -= divisor and quo[0] = 1.
    - Counter increments; after the 32nd step, DIV->FIX.
  - E33: lo = sign_q ? -quo : quo, hi = sign_r ? -rem : rem. After E33: IDLE, busy=0, done=1.
  - Total: busy high 33 cycles.
- Divide by zero (b==0, DIV or DIVU): takes the MUL path timing (busy 1 cycle). Writes lo=32'hFFFFFFFF and hi=a.
- Signed overflow (0x80000000 / -1): the algorithm produces lo=0x80000000 and hi=0 with no special case. Full 33-cycle latency.
- Arithmetic: quotient truncates toward zero; remainder takes the dividend's sign. All subtracts and negations are modulo 2^WIDTH.
- start=1 while busy=1: ignored; latched operands are unaffected.
- An unused op (6, 7) with start=1: no state change, busy stays 0, no done pulse.
- hi/lo change only on write edges or reset; they are stable at all other times, including while busy=1.

Test Plan:
- Reset, then MTHI a=0x12345678 and MTLO a=0x9ABCDEF0 on consecutive cycles -> hi=0x12345678, lo=0x9ABCDEF0 immediately after each edge; busy never asserts; no done pulse.
- MULT a=0xFFFFFFFE, b=3 -> busy high 1 cycle, then done=1 with hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (-7), b=2 -> busy high exactly 33 cycles, then done with lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with the same operands -> lo=0x7FFFFFFC, hi=0x00000001.
- Edge cases:
  - DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0 after 33 cycles.
  - DIVU a=5, b=0 -> after 1 busy cycle, lo=0xFFFFFFFF, hi=5.
- Start a DIV, then pulse start with MULT at cycle 10 of busy -> MULT ignored; DIV result correct at cycle 33. Issue MULT in the cycle done=1 -> it is accepted and completes 1 cycle later.
- Start DIV a=100, b=7, assert reset at busy cycle 15 -> next cycle busy=0, done=0, hi=lo=0. A following DIVU a=100, b=7 -> lo=14, hi=2.
